mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multi-cycle multiply/divide unit. It executes the OP_MUL/OP_DIV codes that the single-cycle ALU returns no result for.
//  Sits beside the ALU in EX and owns the HI/LO register pair.
//  The pipeline issues with a start pulse, stalls on busy, and consumes hi/lo when done pulses.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk          in   1      single clock; all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      issue request; sampled only in IDLE
//  op           in   4      `OP_MUL or `OP_DIV (config.v codes); any other code -> start ignored
//  is_signed    in   1      1 = two's-complement operands, 0 = unsigned
//  A            in   WIDTH  multiplicand / dividend
//  B            in   WIDTH  multiplier / divisor
//  flush        in   1      abort the in-flight operation (exception/branch squash)
//  hi_we        in   1      MTHI write enable
//  lo_we        in   1      MTLO write enable
//  wdata        in   WIDTH  MTHI/MTLO data
//  busy         out  1      operation in flight; pipeline must stall MFHI/MFLO/new mul/div
//  done         out  1      one-cycle pulse; hi/lo hold the new result in this cycle
//  div_by_zero  out  1      valid with done; 1 = DIV with B==0
//  hi           out  WIDTH  MUL: product[63:32]; DIV: remainder
//  lo           out  WIDTH  MUL: product[31:0];  DIV: quotient
// BEHAVIOUR
//  Reset: state IDLE; hi=lo=0; busy=done=div_by_zero=0; iteration counter=0.
//  States: IDLE -> PREP -> CALC (WIDTH cycles) -> FIXUP -> IDLE.
//  IDLE:  start & (op==`OP_MUL | op==`OP_DIV) & !flush -> PREP.
//         Latch op, is_signed, B==0, operand signs, A, B.
//  PREP:  form |A| and |B| (signed mode) or raw values; clear the 2*WIDTH accumulator.
//  CALC:  one bit per cycle, counter 0..WIDTH-1, exit after count WIDTH-1.
//         MUL: shift-add. DIV: restoring; remainder in upper half, quotient shifts into lower.
//  FIXUP: signed MUL negates the 64-bit product if the operand signs differ.
//         Signed DIV negates the quotient if the signs differ and gives the remainder the dividend's sign.
//         Registers hi/lo; next state IDLE and done=1 for exactly one cycle.
//  Timing: start sampled at edge 0; busy=1 in cycles 1..WIDTH+2; done=1 in cycle WIDTH+3 (35 @32).
//          Latency is fixed and data-independent, including divide-by-zero.
//  A new start is accepted in the done cycle (back-to-back issue).
//  start while busy: ignored, with no queueing.
//  Divide by zero: hi = latched A, lo = all-ones, div_by_zero=1 with done; signed or unsigned alike.
//  Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0, div_by_zero=0 (mod-2^WIDTH wrap).
//  flush: valid in every state. Next state IDLE, busy=0, no done, hi/lo unchanged.
//         flush beats start in the same cycle.
//  hi_we/lo_we: honoured only when busy=0, ignored while busy.
//         Same cycle as an accepted start: the write lands and the op still starts; the result later overwrites it.
//  div_by_zero holds its value until the next done; reset clears it.
//  All widths are WIDTH or 2*WIDTH. Negation is two's complement mod 2^width, with no saturation.
// STRUCTURE
//  config.v: add MDU_IDLE/MDU_PREP/MDU_CALC/MDU_FIXUP state encodings (2 bits).
//  Reuse the existing `OP_MUL/`OP_DIV codes.
//  One sub-module: mdu_sign_fix. Combinational conditional two's-complement negate, used in PREP and FIXUP.
//  FSM, counter, accumulator and HI/LO stay in mul_div_unit.
// TESTING
//  1. MUL unsigned A=B=0xFFFFFFFF -> done in cycle 35; hi=0xFFFFFFFE, lo=0x00000001; busy in cycles 1..34 only.
//  2. MUL signed A=-3, B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  3. DIV signed A=-7, B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_by_zero=0.
//  4. DIV A=100, B=0, both signs -> hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1, done in cycle 35.
//  5. DIV signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//     Then restart in the done cycle -> second done exactly 35 cycles later.
//  6. Start a MUL, flush in cycle 10 and assert start in cycle 5 -> the cycle-5 start is ignored.
//     After the flush: busy=0 in cycle 11, no done, hi/lo keep their prior values.
//     lo_we with wdata=0x1234 in cycle 12 -> lo=0x1234.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared opcodes, FSM state encodings and helpers for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1011;

    typedef enum logic [1:0] {
        MDU_IDLE  = 2'd0,
        MDU_PREP  = 2'd1,
        MDU_CALC  = 2'd2,
        MDU_FIXUP = 2'd3
    } mdu_state_e;

    function automatic logic is_mdu_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Pipeline-side request/result bundle of the multiply/divide unit; master = pipeline, slave = unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);

    logic             start;
    logic [3:0]       op;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, is_signed, a, b, flush, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, is_signed, a, b, flush, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negate (mod 2^N); used for operand magnitudes and result sign repair.
module mdu_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] val,
    input  logic         neg,
    output logic [N-1:0] res
);

    assign res = neg ? (~val + N'(1)) : val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MUL/DIV unit owning HI/LO: fixed WIDTH+3 cycle latency from start to a one-cycle done pulse.
// Busy covers PREP, CALC and FIXUP; flush aborts at any point without touching HI/LO.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mdu_state_e         state, state_nxt;
    logic               done_nxt;
    logic               accept;
    logic               busy_int;

    logic               is_div;
    logic               sa, sb;
    logic               b_zero;
    logic [WIDTH-1:0]   a_lat, b_lat;
    logic [WIDTH-1:0]   ma, mb;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_q;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    logic [WIDTH:0]     trial;
    logic               trial_ge;
    logic [WIDTH-1:0]   rem_nxt;
    logic [2*WIDTH-1:0] mul_nxt;

    assign busy_int = (state != MDU_IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= MDU_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        unique case (state)
            MDU_IDLE: begin
                if (bus.start && is_mdu_op(bus.op)) begin
                    state_nxt = MDU_PREP;
                    accept    = 1'b1;
                end
            end
            MDU_PREP:  state_nxt = MDU_CALC;
            MDU_CALC: begin
                if (cnt == CW'(WIDTH - 1)) state_nxt = MDU_FIXUP;
            end
            MDU_FIXUP: begin
                state_nxt = MDU_IDLE;
                done_nxt  = 1'b1;
            end
            default:   state_nxt = MDU_IDLE;
        endcase
        // Squash wins over everything, including a same-cycle start.
        if (bus.flush) begin
            state_nxt = MDU_IDLE;
            done_nxt  = 1'b0;
            accept    = 1'b0;
        end
    end

    // ---------------- sign handling ----------------
    mdu_sign_fix #(.N(WIDTH)) u_fix_a (.val(a_lat), .neg(sa), .res(abs_a));
    mdu_sign_fix #(.N(WIDTH)) u_fix_b (.val(b_lat), .neg(sb), .res(abs_b));
    mdu_sign_fix #(.N(2*WIDTH)) u_fix_prod (.val(acc), .neg(sa ^ sb), .res(prod_fix));
    mdu_sign_fix #(.N(WIDTH)) u_fix_quo (.val(acc[WIDTH-1:0]), .neg(sa ^ sb), .res(quo_fix));
    mdu_sign_fix #(.N(WIDTH)) u_fix_rem (.val(acc[2*WIDTH-1:WIDTH]), .neg(sa), .res(rem_fix));

    // ---------------- one iteration step ----------------
    // Divide: dividend bits leave ma MSB-first; remainder never exceeds divisor so WIDTH bits suffice.
    always_comb begin
        trial    = {acc[2*WIDTH-1:WIDTH], ma[WIDTH-1]};
        trial_ge = (trial >= {1'b0, mb});
        rem_nxt  = trial_ge ? (trial[WIDTH-1:0] - mb) : trial[WIDTH-1:0];
        mul_nxt  = {acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, (mb[WIDTH-1] ? ma : {WIDTH{1'b0}})};
    end

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_lat;
                res_lo = {WIDTH{1'b1}};
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    // ---------------- operand latch, accumulator, counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            b_zero <= 1'b0;
            a_lat  <= '0;
            b_lat  <= '0;
            ma     <= '0;
            mb     <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                is_div <= (bus.op == OP_DIV);
                sa     <= bus.is_signed & bus.a[WIDTH-1];
                sb     <= bus.is_signed & bus.b[WIDTH-1];
                b_zero <= (bus.b == '0);
                a_lat  <= bus.a;
                b_lat  <= bus.b;
            end
            case (state)
                MDU_PREP: begin
                    ma  <= abs_a;
                    mb  <= abs_b;
                    acc <= '0;
                    cnt <= '0;
                end
                MDU_CALC: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        ma  <= {ma[WIDTH-2:0], 1'b0};
                        acc <= {rem_nxt, acc[WIDTH-2:0], trial_ge};
                    end else begin
                        mb  <= {mb[WIDTH-2:0], 1'b0};
                        acc <= mul_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- HI/LO and result flags ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= done_nxt;
            if (done_nxt) begin
                hi_q  <= res_hi;
                lo_q  <= res_lo;
                dbz_q <= is_div & b_zero;
            end else if (!busy_int) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy        = busy_int;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: cycle-exact latency, arithmetic corners, flush and MTHI/MTLO.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          r_done_cyc, r_bfirst, r_blast, r_bcnt;
    logic [31:0] r_hi, r_lo, r_lo_c1;
    logic        r_dbz;

    // Issues one op from the current negedge; returns in the done cycle (or after a bounded wait).
    task automatic run_op(input logic [3:0] op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int c;
        bus.start = 1'b1; bus.op = op; bus.is_signed = sgn; bus.a = a; bus.b = b;
        r_done_cyc = 0; r_bfirst = 0; r_blast = 0; r_bcnt = 0;
        r_hi = 'x; r_lo = 'x; r_dbz = 1'bx; r_lo_c1 = 'x;
        @(posedge clk);
        c = 0;
        while (c < 45 && r_done_cyc == 0) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
                r_lo_c1 = bus.lo;
            end
            if (bus.busy) begin
                r_bcnt++;
                if (r_bfirst == 0) r_bfirst = c;
                r_blast = c;
            end
            if (bus.done) begin
                r_done_cyc = c; r_hi = bus.hi; r_lo = bus.lo; r_dbz = bus.div_by_zero;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 4'd0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
        bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b dbz=%b, expected 0 0 0", bus.busy, bus.done, bus.div_by_zero);
        end
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: got hi=%h lo=%h, expected 0 0", bus.hi, bus.lo);
        end
    endtask

    task automatic test_mul_unsigned();
        run_op(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (r_done_cyc !== 35) begin errors++; $display("FAIL mulu_latency: got cycle %0d, expected 35", r_done_cyc); end
        checks++;
        if (r_bfirst !== 1 || r_blast !== 34 || r_bcnt !== 34) begin
            errors++;
            $display("FAIL mulu_busy: got first=%0d last=%0d count=%0d, expected 1 34 34", r_bfirst, r_blast, r_bcnt);
        end
        checks++;
        if (r_hi !== 32'hFFFF_FFFE || r_lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL mulu_result: got hi=%h lo=%h, expected fffffffe 00000001", r_hi, r_lo);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mulu_done_pulse: got done=%b busy=%b after done, expected 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_mul_signed();
        run_op(OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7);
        checks++;
        if (r_done_cyc !== 35 || r_hi !== 32'hFFFF_FFFF || r_lo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL muls_result: got cyc=%0d hi=%h lo=%h, expected 35 ffffffff ffffffeb", r_done_cyc, r_hi, r_lo);
        end
    endtask

    task automatic test_div_signed();
        run_op(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (r_lo !== 32'hFFFF_FFFD || r_hi !== 32'hFFFF_FFFF || r_dbz !== 1'b0) begin
            errors++;
            $display("FAIL divs_result: got hi=%h lo=%h dbz=%b, expected ffffffff fffffffd 0", r_hi, r_lo, r_dbz);
        end
    endtask

    task automatic test_div_by_zero();
        for (int s = 0; s < 2; s++) begin
            run_op(OP_DIV, s[0], 32'd100, 32'd0);
            checks++;
            if (r_done_cyc !== 35 || r_hi !== 32'h0000_0064 || r_lo !== 32'hFFFF_FFFF || r_dbz !== 1'b1) begin
                errors++;
                $display("FAIL div0_signed%0d: got cyc=%0d hi=%h lo=%h dbz=%b, expected 35 00000064 ffffffff 1",
                         s, r_done_cyc, r_hi, r_lo, r_dbz);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div0_hold: got dbz=%b after done, expected 1", bus.div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        run_op(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (r_lo !== 32'h8000_0000 || r_hi !== 32'h0 || r_dbz !== 1'b0) begin
            errors++;
            $display("FAIL div_overflow: got hi=%h lo=%h dbz=%b, expected 00000000 80000000 0", r_hi, r_lo, r_dbz);
        end
        run_op(OP_DIV, 1'b0, 32'd100, 32'd7);
        checks++;
        if (r_done_cyc !== 35 || r_lo !== 32'd14 || r_hi !== 32'd2) begin
            errors++;
            $display("FAIL b2b_second: got cyc=%0d hi=%h lo=%h, expected 35 00000002 0000000e", r_done_cyc, r_hi, r_lo);
        end
    endtask

    task automatic test_mtlo_with_start();
        bus.lo_we = 1'b1; bus.wdata = 32'h0000_0777;
        run_op(OP_MUL, 1'b0, 32'd2, 32'd3);
        checks++;
        if (r_lo_c1 !== 32'h0000_0777) begin
            errors++;
            $display("FAIL mtlo_start_write: got lo=%h in cycle 1, expected 00000777", r_lo_c1);
        end
        checks++;
        if (r_done_cyc !== 35 || r_lo !== 32'd6 || r_hi !== 32'd0) begin
            errors++;
            $display("FAIL mtlo_start_result: got cyc=%0d hi=%h lo=%h, expected 35 00000000 00000006", r_done_cyc, r_hi, r_lo);
        end
    endtask

    task automatic test_flush();
        int seen_done;
        @(negedge clk);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hAAAA_0000;
        @(negedge clk);
        bus.lo_we = 1'b1; bus.hi_we = 1'b0; bus.wdata = 32'h0000_5555;
        @(negedge clk);
        bus.lo_we = 1'b0;
        checks++;
        if (bus.hi !== 32'hAAAA_0000 || bus.lo !== 32'h0000_5555) begin
            errors++;
            $display("FAIL mthi_mtlo: got hi=%h lo=%h, expected aaaa0000 00005555", bus.hi, bus.lo);
        end
        // flush beats start; an unknown opcode is ignored
        bus.start = 1'b1; bus.op = OP_MUL; bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0; bus.op = 4'h0;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_or_badop_start: got busy=%b, expected 0", bus.busy); end

        bus.start = 1'b1; bus.op = OP_MUL; bus.is_signed = 1'b0; bus.a = 32'd5; bus.b = 32'd6;
        @(posedge clk);
        seen_done = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.flush = 1'b0;
            if (bus.done) seen_done++;
            if (c == 3) begin bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF; end
            if (c == 5) begin bus.start = 1'b1; bus.op = OP_MUL; end
            if (c == 10) bus.flush = 1'b1;
            if (c == 11) begin
                checks++;
                if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got busy=%b in cycle 11, expected 0", bus.busy); end
                checks++;
                if (bus.hi !== 32'hAAAA_0000 || bus.lo !== 32'h0000_5555) begin
                    errors++;
                    $display("FAIL flush_hilo: got hi=%h lo=%h, expected aaaa0000 00005555", bus.hi, bus.lo);
                end
            end
            if (c == 12) begin bus.lo_we = 1'b1; bus.wdata = 32'h0000_1234; end
            if (c == 13) begin
                checks++;
                if (bus.lo !== 32'h0000_1234 || bus.hi !== 32'hAAAA_0000) begin
                    errors++;
                    $display("FAIL flush_mtlo: got hi=%h lo=%h, expected aaaa0000 00001234", bus.hi, bus.lo);
                end
            end
        end
        checks++;
        if (seen_done !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_done: got %0d done pulses busy=%b, expected 0 0", seen_done, bus.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mul_unsigned();
        test_mul_signed();
        test_div_signed();
        test_div_by_zero();
        test_back_to_back();
        test_mtlo_with_start();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
